// File: rtl/id_gen.sv
// id_gen: identifier token generator for the id_fsm recogniser.
// Emits letters, digits, then one separator, with the expected id_fsm output.
module id_gen #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] letters,
    input  logic [LEN_W-1:0] digits,
    input  logic [7:0]       base_letter,
    input  logic [7:0]       sep,
    output logic [7:0]       char,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             exp_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LET  = 2'd1,
        DIG  = 2'd2,
        SEP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             exp_q, exp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] let_q, let_d;
    logic [LEN_W-1:0] dig_q, dig_d;
    logic [7:0]       sep_q, sep_d;
    logic             has_let_q, has_let_d;

    logic [7:0] base_clean;
    logic [7:0] sep_clean;
    logic [7:0] next_letter;
    logic [7:0] next_digit;
    logic       xfer;

    // Sanitise inputs so the token always starts with a letter and ends the run
    always_comb begin
        base_clean = base_letter;
        sep_clean  = sep;
        if (!((base_letter >= 8'h41 && base_letter <= 8'h5a) ||
              (base_letter >= 8'h61 && base_letter <= 8'h7a)))
            base_clean = 8'h61;
        if ((sep >= 8'h41 && sep <= 8'h5a) ||
            (sep >= 8'h61 && sep <= 8'h7a) ||
            (sep >= 8'h30 && sep <= 8'h39))
            sep_clean = 8'h20;
    end

    // Successor characters, wrapping within case and within 0-9
    always_comb begin
        next_letter = char_q + 8'd1;
        next_digit  = char_q + 8'd1;
        if (char_q == 8'h7a)
            next_letter = 8'h61;
        else if (char_q == 8'h5a)
            next_letter = 8'h41;
        if (char_q == 8'h39)
            next_digit = 8'h30;
    end

    // Next-state and output logic; a transfer advances the token
    always_comb begin
        state_d   = state_q;
        char_d    = char_q;
        valid_d   = valid_q;
        exp_d     = exp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        let_d     = let_q;
        dig_d     = dig_q;
        sep_d     = sep_q;
        has_let_d = has_let_q;
        xfer      = valid_q && char_ready;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    let_d     = letters;
                    dig_d     = digits;
                    sep_d     = sep_clean;
                    has_let_d = (letters != '0);
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    exp_d     = 1'b0;
                    if (letters != '0) begin
                        state_d = LET;
                        char_d  = base_clean;
                    end else if (digits != '0) begin
                        state_d = DIG;
                        char_d  = 8'h30;
                    end else begin
                        state_d = SEP;
                        char_d  = sep_clean;
                    end
                end
            end
            LET: begin
                if (xfer) begin
                    if (let_q == LEN_W'(1)) begin
                        let_d = '0;
                        if (dig_q != '0) begin
                            state_d = DIG;
                            char_d  = 8'h30;
                            exp_d   = has_let_q;
                        end else begin
                            state_d = SEP;
                            char_d  = sep_q;
                            exp_d   = 1'b0;
                        end
                    end else begin
                        let_d  = let_q - LEN_W'(1);
                        char_d = next_letter;
                    end
                end
            end
            DIG: begin
                if (xfer) begin
                    if (dig_q == LEN_W'(1)) begin
                        dig_d   = '0;
                        state_d = SEP;
                        char_d  = sep_q;
                        exp_d   = 1'b0;
                    end else begin
                        dig_d  = dig_q - LEN_W'(1);
                        char_d = next_digit;
                    end
                end
            end
            SEP: begin
                if (xfer) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    exp_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            char_q    <= '0;
            valid_q   <= 1'b0;
            exp_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            let_q     <= '0;
            dig_q     <= '0;
            sep_q     <= '0;
            has_let_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            char_q    <= char_d;
            valid_q   <= valid_d;
            exp_q     <= exp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            let_q     <= let_d;
            dig_q     <= dig_d;
            sep_q     <= sep_d;
            has_let_q <= has_let_d;
        end
    end

    assign char       = char_q;
    assign char_valid = valid_q;
    assign exp_out    = exp_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/id_gen.md
Name: id_gen

Overview:
Character-stream generator that produces identifier test strings for the id_fsm recogniser. One start command emits one token, one character per handshake: a run of letters, then a run of digits, then one separator. Alongside each character it drives the id_fsm output value that character must produce. It is used as the stimulus and check source in front of id_fsm and any later lexer blocks.

Parameters:
LEN_W, 4, width of the letter and digit count inputs. Each count ranges 0 to 2^LEN_W-1.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request a new token. Sampled only while busy==0.
letters  in  LEN_W  number of letters to emit.
digits  in  LEN_W  number of digits to emit.
base_letter  in  8  ASCII code of the first letter.
sep  in  8  ASCII code of the separator.
char  out  8  current character, registered.
char_valid  out  1  char holds a valid character.
char_ready  in  1  consumer accepts char this cycle.
exp_out  out  1  value id_fsm.out must take after it consumes char.
busy  out  1  a token is in progress.
done  out  1  one-cycle pulse when a token completes.

Behaviour:
- Async reset: state=IDLE; char=0, char_valid=0, exp_out=0, busy=0, done=0.
- States: IDLE, LET, DIG, SEP.
- Start acceptance (IDLE with start=1 at an edge):
  - Latch letters, digits and the sanitised base_letter and sep.
  - base_letter that is not in A-Z or a-z is replaced by "a".
  - sep that is a letter or digit is replaced by " " (space). This guarantees the token ends id_fsm's run.
  - Next state: LET if letters>0, else DIG if digits>0, else SEP.
  - busy=1 and char_valid=1 from the next cycle, carrying the first character.
- Transfer rule:
  - A character transfers on an edge where char_valid && char_ready.
  - While char_valid=1 and char_ready=0, char and exp_out hold stable.
  - After a transfer, the next character is presented in the following cycle with no bubble.
- LET: the i-th letter (i from 0) is base+i, wrapping within its own case ("z"->"a", "Z"->"A"); exp_out=0. After the last letter, go to DIG if digits>0, else SEP.
- DIG: the j-th digit is "0"+(j mod 10); exp_out=1 if letters>0, else 0. After the last digit, go to SEP.
- SEP: emits the separator once with exp_out=0.
  - On its transfer: state=IDLE, char_valid=0, busy=0, done=1 for exactly one cycle.
- start while busy=1 is ignored with no effect. start in the done cycle is accepted, since busy=0.
- letters=digits=0: the token is the separator alone.
- Reset mid-token: the token is aborted immediately, all outputs take reset values, and no done pulse is produced.
- Counters are LEN_W bits and count down from the latched value. The maximum count (15) emits exactly 15 characters.

Test Plan:
- letters=3, digits=2, base="x", sep=" ", char_ready=1 -> chars "x","y","z","0","1"," " on 6 consecutive cycles; exp_out 0,0,0,1,1,0; done pulses once the cycle after " " transfers; busy high for 6 cycles.
- base="Y", letters=4, digits=0, sep="," -> "Y","Z","A","B",","; exp_out all 0.
- letters=1, digits=12, base="k" -> "k", then "0".."9","0","1", then " "; exp_out=1 on all 12 digits. Connect id_fsm on char and check its out against exp_out on every transfer.
- letters=0, digits=2, base="5", sep="q" -> "0","1"," " with exp_out 0,0,0 (sep "q" sanitised to space). A second run with letters=2 shows base "5" sanitised to "a": emits "a","b".
- Backpressure: letters=2, digits=2, base="a", char_ready low for 3 cycles while "b" is presented -> char stays "b" with char_valid=1 throughout; the sequence resumes "0","1"," " with nothing lost or duplicated. A start pulse during the token is ignored.
- Assert reset for 1 cycle while "1" is presented in a 5-character token -> char_valid=0, busy=0, done=0, char=0 next; no done pulse. A fresh start then generates a complete token correctly.
